// File: rtl/block_move_sched.sv
// Sequences one falling-block move: erase at the old position, then draw at the new one.
// Owns the VGA write port, buffers one pending move and aborts hung engines with a watchdog.
module block_move_sched #(
    parameter int X_W     = 7,
    parameter int Y_W     = 7,
    parameter int C_W     = 3,
    parameter int TIMEOUT = 1024
) (
    input  logic           clock,
    input  logic           resetn,
    input  logic           move_req,
    input  logic [X_W-1:0] new_x,
    input  logic [Y_W-1:0] new_y,
    input  logic [C_W-1:0] new_colour,
    input  logic           err_clr,
    output logic           erase_go,
    output logic [X_W-1:0] erase_x,
    output logic [Y_W-1:0] erase_y,
    input  logic           erase_done,
    input  logic [X_W-1:0] e_x,
    input  logic [Y_W-1:0] e_y,
    input  logic [C_W-1:0] e_colour,
    input  logic           e_plot,
    output logic           draw_go,
    output logic [X_W-1:0] draw_x,
    output logic [Y_W-1:0] draw_y,
    output logic [C_W-1:0] draw_colour,
    input  logic           draw_done,
    input  logic [X_W-1:0] d_x,
    input  logic [Y_W-1:0] d_y,
    input  logic [C_W-1:0] d_colour,
    input  logic           d_plot,
    output logic [X_W-1:0] vga_x,
    output logic [Y_W-1:0] vga_y,
    output logic [C_W-1:0] vga_colour,
    output logic           vga_plot,
    output logic           busy,
    output logic           move_done,
    output logic           err
);

    localparam int T_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        IDLE,
        ERASE_GO,
        ERASE_WAIT,
        DRAW_GO,
        DRAW_WAIT,
        DONE
    } state_t;

    state_t         state_reg, state_next;
    logic [X_W-1:0] cur_x_reg, tgt_x_reg, pend_x_reg;
    logic [Y_W-1:0] cur_y_reg, tgt_y_reg, pend_y_reg;
    logic [C_W-1:0] tgt_col_reg, pend_col_reg;
    logic           have_pos_reg;
    logic           pending_reg;
    logic           err_reg;
    logic [T_W-1:0] timer_reg;
    logic           timer_expired;
    logic           abort;

    // Abort on the cycle whose increment would bring the timer to TIMEOUT-1.
    assign timer_expired = (timer_reg == T_W'(TIMEOUT - 2));

    always_comb begin
        state_next = state_reg;
        abort      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (move_req || pending_reg) begin
                    state_next = have_pos_reg ? ERASE_GO : DRAW_GO;
                end
            end
            ERASE_GO:   state_next = ERASE_WAIT;
            ERASE_WAIT: begin
                if (erase_done) begin
                    state_next = DRAW_GO;
                end else if (timer_expired) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end
            end
            DRAW_GO:    state_next = DRAW_WAIT;
            DRAW_WAIT: begin
                if (draw_done) begin
                    state_next = DONE;
                end else if (timer_expired) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end
            end
            DONE:       state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
            timer_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ERASE_GO || state_reg == DRAW_GO) begin
                timer_reg <= '0;
            end else if (state_reg == ERASE_WAIT || state_reg == DRAW_WAIT) begin
                timer_reg <= timer_reg + 1'b1;
            end
            if (abort) begin
                err_reg <= 1'b1;
            end else if (err_clr) begin
                err_reg <= 1'b0;
            end
        end
    end

    // Target, pending buffer and committed position.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tgt_x_reg    <= '0;
            tgt_y_reg    <= '0;
            tgt_col_reg  <= '0;
            pend_x_reg   <= '0;
            pend_y_reg   <= '0;
            pend_col_reg <= '0;
            pending_reg  <= 1'b0;
            cur_x_reg    <= '0;
            cur_y_reg    <= '0;
            have_pos_reg <= 1'b0;
        end else begin
            if (state_reg == IDLE) begin
                if (move_req) begin
                    tgt_x_reg   <= new_x;
                    tgt_y_reg   <= new_y;
                    tgt_col_reg <= new_colour;
                end else if (pending_reg) begin
                    tgt_x_reg   <= pend_x_reg;
                    tgt_y_reg   <= pend_y_reg;
                    tgt_col_reg <= pend_col_reg;
                end
                pending_reg <= 1'b0;
            end else if (abort) begin
                pending_reg <= 1'b0;
            end else if (move_req) begin
                pend_x_reg   <= new_x;
                pend_y_reg   <= new_y;
                pend_col_reg <= new_colour;
                pending_reg  <= 1'b1;
            end
            if (state_reg == DONE) begin
                cur_x_reg    <= tgt_x_reg;
                cur_y_reg    <= tgt_y_reg;
                have_pos_reg <= 1'b1;
            end
        end
    end

    assign erase_go    = (state_reg == ERASE_GO);
    assign draw_go     = (state_reg == DRAW_GO);
    assign move_done   = (state_reg == DONE);
    assign busy        = (state_reg != IDLE);
    assign err         = err_reg;
    assign erase_x     = cur_x_reg;
    assign erase_y     = cur_y_reg;
    assign draw_x      = tgt_x_reg;
    assign draw_y      = tgt_y_reg;
    assign draw_colour = tgt_col_reg;

    always_comb begin
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        vga_plot   = 1'b0;
        case (state_reg)
            ERASE_GO, ERASE_WAIT: begin
                vga_x      = e_x;
                vga_y      = e_y;
                vga_colour = e_colour;
                vga_plot   = e_plot;
            end
            DRAW_GO, DRAW_WAIT: begin
                vga_x      = d_x;
                vga_y      = d_y;
                vga_colour = d_colour;
                vga_plot   = d_plot;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_block_move_sched.sv
// Bench for block_move_sched: directed move table, corner sequences, a short-timeout
// watchdog instance, and randomized requests checked against a transaction-level model.
module tb_block_move_sched;

    logic clock;
    logic resetn;
    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic       move_req, err_clr, erase_done, draw_done;
    logic [6:0] new_x, new_y, e_x, e_y, d_x, d_y;
    logic [2:0] new_colour, e_colour, d_colour;
    logic       e_plot, d_plot;
    logic       erase_go, draw_go, busy, move_done, err, vga_plot;
    logic [6:0] erase_x, erase_y, draw_x, draw_y, vga_x, vga_y;
    logic [2:0] draw_colour, vga_colour;

    logic       w_move_req, w_err_clr, w_erase_done, w_draw_done;
    logic [6:0] w_new_x, w_new_y;
    logic [2:0] w_new_colour;
    logic       w_erase_go, w_draw_go, w_busy, w_move_done, w_err, w_vga_plot;
    logic [6:0] w_erase_x, w_erase_y, w_draw_x, w_draw_y, w_vga_x, w_vga_y;
    logic [2:0] w_draw_colour, w_vga_colour;

    block_move_sched #(.X_W(7), .Y_W(7), .C_W(3), .TIMEOUT(1024)) u_dut (
        .clock(clock), .resetn(resetn), .move_req(move_req), .new_x(new_x), .new_y(new_y),
        .new_colour(new_colour), .err_clr(err_clr), .erase_go(erase_go), .erase_x(erase_x),
        .erase_y(erase_y), .erase_done(erase_done), .e_x(e_x), .e_y(e_y), .e_colour(e_colour),
        .e_plot(e_plot), .draw_go(draw_go), .draw_x(draw_x), .draw_y(draw_y),
        .draw_colour(draw_colour), .draw_done(draw_done), .d_x(d_x), .d_y(d_y),
        .d_colour(d_colour), .d_plot(d_plot), .vga_x(vga_x), .vga_y(vga_y),
        .vga_colour(vga_colour), .vga_plot(vga_plot), .busy(busy), .move_done(move_done),
        .err(err)
    );

    block_move_sched #(.X_W(7), .Y_W(7), .C_W(3), .TIMEOUT(16)) u_wd (
        .clock(clock), .resetn(resetn), .move_req(w_move_req), .new_x(w_new_x), .new_y(w_new_y),
        .new_colour(w_new_colour), .err_clr(w_err_clr), .erase_go(w_erase_go),
        .erase_x(w_erase_x), .erase_y(w_erase_y), .erase_done(w_erase_done), .e_x(e_x),
        .e_y(e_y), .e_colour(e_colour), .e_plot(e_plot), .draw_go(w_draw_go),
        .draw_x(w_draw_x), .draw_y(w_draw_y), .draw_colour(w_draw_colour),
        .draw_done(w_draw_done), .d_x(d_x), .d_y(d_y), .d_colour(d_colour), .d_plot(d_plot),
        .vga_x(w_vga_x), .vga_y(w_vga_y), .vga_colour(w_vga_colour), .vga_plot(w_vga_plot),
        .busy(w_busy), .move_done(w_move_done), .err(w_err)
    );

    typedef struct { logic [6:0] x; logic [6:0] y; logic [2:0] c; } mv_t;
    typedef struct { logic has_erase; logic [6:0] ex; logic [6:0] ey; mv_t t; } exp_t;
    typedef struct {
        logic [6:0] x; logic [6:0] y; logic [2:0] c; int ed; int dd;
        logic exp_erase; logic [6:0] ex; logic [6:0] ey;
    } vec_t;

    // Transaction-level model: moves are started when the block is free, else parked
    exp_t       exp_q[$];
    mv_t        req_mv, m_pend_mv;
    bit         req_now, done_now, m_busy, m_pend, m_have;
    logic [6:0] m_cx, m_cy;

    int n_vec, n_err, n_started, n_done, n_draws, cyc, done_cyc;
    int er_cnt, dr_cnt, e_delay, d_delay, phase;
    bit end_phase, er_fin, rand_delays, stray_dd, saw_erase, wd_done_seen;
    logic [6:0] last_ex, last_ey, last_dx, last_dy;
    logic [2:0] last_dc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic void start_move(input mv_t m);
        exp_t e;
        e.has_erase = m_have;
        e.ex = m_cx;
        e.ey = m_cy;
        e.t = m;
        exp_q.push_back(e);
        m_cx = m.x;
        m_cy = m.y;
        m_have = 1'b1;
        m_busy = 1'b1;
        n_started++;
    endfunction

    task automatic req(input logic [6:0] x, input logic [6:0] y, input logic [2:0] c);
        move_req = 1'b1;
        new_x = x;
        new_y = y;
        new_colour = c;
        req_now = 1'b1;
        req_mv = '{x: x, y: y, c: c};
    endtask

    // One clock: commit the model decision for the ending cycle, then observe and drive.
    task automatic tick();
        logic [17:0] vga_exp;
        if (m_busy) begin
            if (req_now) begin m_pend = 1'b1; m_pend_mv = req_mv; end
            if (done_now) m_busy = 1'b0;
        end else if (req_now) begin
            start_move(req_mv);
            m_pend = 1'b0;
        end else if (m_pend) begin
            start_move(m_pend_mv);
            m_pend = 1'b0;
        end
        req_now = 1'b0;
        done_now = 1'b0;
        @(posedge clock);
        #1;
        cyc++;
        move_req = 1'b0; err_clr = 1'b0; erase_done = 1'b0; draw_done = 1'b0;
        if (end_phase) phase = 0;
        end_phase = 1'b0;
        if (er_cnt > 0) begin
            er_cnt--;
            if (er_cnt == 0) begin erase_done = 1'b1; end_phase = 1'b1; er_fin = 1'b1; end
        end
        if (dr_cnt > 0) begin
            dr_cnt--;
            if (dr_cnt == 0) begin draw_done = 1'b1; end_phase = 1'b1; end
        end
        if (stray_dd) begin draw_done = 1'b1; stray_dd = 1'b0; end
        if (erase_go) begin
            phase = 1; saw_erase = 1'b1; last_ex = erase_x; last_ey = erase_y;
            er_cnt = rand_delays ? int'($urandom_range(6, 1)) : e_delay;
            chk("erase_go_queue", exp_q.size(), 1);
            if (exp_q.size() > 0) begin
                chk("erase_expected", 32'(erase_go), 32'(exp_q[0].has_erase));
                chk("erase_xy", 32'({erase_x, erase_y}), 32'({exp_q[0].ex, exp_q[0].ey}));
            end
        end
        if (draw_go) begin
            phase = 2; n_draws++;
            last_dx = draw_x; last_dy = draw_y; last_dc = draw_colour;
            dr_cnt = rand_delays ? int'($urandom_range(6, 1)) : d_delay;
            chk("draw_go_queue", exp_q.size(), 1);
            if (exp_q.size() > 0) begin
                chk("erase_before_draw", 32'(er_fin), 32'(exp_q[0].has_erase));
                chk("draw_target", 32'({draw_x, draw_y, draw_colour}),
                    32'({exp_q[0].t.x, exp_q[0].t.y, exp_q[0].t.c}));
                void'(exp_q.pop_front());
            end
            er_fin = 1'b0;
        end
        if (move_done) begin
            done_now = 1'b1; n_done++; done_cyc = cyc;
            $display("move %0d complete at cycle %0d -> (%0d,%0d) colour %0d",
                     n_done, cyc, last_dx, last_dy, last_dc);
        end
        e_x = 7'($urandom); e_y = 7'($urandom); e_colour = 3'($urandom); e_plot = 1'($urandom);
        d_x = 7'($urandom); d_y = 7'($urandom); d_colour = 3'($urandom); d_plot = 1'($urandom);
        #1;
        case (phase)
            1:       vga_exp = {e_x, e_y, e_colour, e_plot};
            2:       vga_exp = {d_x, d_y, d_colour, d_plot};
            default: vga_exp = '0;
        endcase
        chk("vga_mux", 32'({vga_x, vga_y, vga_colour, vga_plot}), 32'(vga_exp));
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 400 && (m_busy || m_pend || done_now); k++) tick();
        chk("model_idle", 32'({m_busy, m_pend, done_now}), 0);
    endtask

    task automatic run_until_done(input int limit, input string name);
        bit got;
        got = 1'b0;
        for (int k = 0; k < limit && !got; k++) begin
            tick();
            if (move_done) got = 1'b1;
        end
        chk(name, 32'(got), 1);
    endtask

    vec_t tbl[5];
    int   base, c0;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{x: 7'd10,  y: 7'd20,  c: 3'd5, ed: 1, dd: 300, exp_erase: 1'b0, ex: 7'd0,   ey: 7'd0};
        tbl[1] = '{x: 7'd10,  y: 7'd21,  c: 3'd5, ed: 4, dd: 3,   exp_erase: 1'b1, ex: 7'd10,  ey: 7'd20};
        tbl[2] = '{x: 7'd0,   y: 7'd0,   c: 3'd0, ed: 1, dd: 1,   exp_erase: 1'b1, ex: 7'd10,  ey: 7'd21};
        tbl[3] = '{x: 7'd127, y: 7'd127, c: 3'd7, ed: 2, dd: 1,   exp_erase: 1'b1, ex: 7'd0,   ey: 7'd0};
        tbl[4] = '{x: 7'd64,  y: 7'd3,   c: 3'd2, ed: 7, dd: 5,   exp_erase: 1'b1, ex: 7'd127, ey: 7'd127};

        resetn = 1'b0;
        move_req = 0; err_clr = 0; erase_done = 0; draw_done = 0;
        new_x = 0; new_y = 0; new_colour = 0;
        e_x = 0; e_y = 0; e_colour = 0; e_plot = 0; d_x = 0; d_y = 0; d_colour = 0; d_plot = 0;
        w_move_req = 0; w_err_clr = 0; w_erase_done = 0; w_draw_done = 0;
        w_new_x = 0; w_new_y = 0; w_new_colour = 0;
        n_vec = 0; n_err = 0; n_started = 0; n_done = 0; n_draws = 0; cyc = 0;
        er_cnt = 0; dr_cnt = 0; phase = 0; e_delay = 1; d_delay = 1;
        m_busy = 0; m_pend = 0; m_have = 0; m_cx = 0; m_cy = 0; req_now = 0; done_now = 0;
        end_phase = 0; er_fin = 0; rand_delays = 0; stray_dd = 0; saw_erase = 0;

        repeat (3) @(posedge clock);
        #1;
        chk("reset_ctrl", 32'({busy, erase_go, draw_go, move_done, err}), 0);
        chk("reset_vga", 32'({vga_x, vga_y, vga_colour, vga_plot}), 0);
        chk("reset_coords", 32'({erase_x, erase_y, draw_x, draw_y, draw_colour}), 0);
        @(negedge clock);
        resetn = 1'b1;

        // Directed move table
        for (int i = 0; i < 5; i++) begin
            wait_idle();
            e_delay = tbl[i].ed; d_delay = tbl[i].dd; saw_erase = 1'b0;
            req(tbl[i].x, tbl[i].y, tbl[i].c);
            run_until_done(tbl[i].ed + tbl[i].dd + 20, "vec_move_done");
            chk("vec_erase_seen", 32'(saw_erase), 32'(tbl[i].exp_erase));
            if (tbl[i].exp_erase)
                chk("vec_erase_xy", 32'({last_ex, last_ey}), 32'({tbl[i].ex, tbl[i].ey}));
            chk("vec_draw", 32'({last_dx, last_dy, last_dc}), 32'({tbl[i].x, tbl[i].y, tbl[i].c}));
            tick();
            chk("vec_cur_xy", 32'({erase_x, erase_y}), 32'({tbl[i].x, tbl[i].y}));
            chk("vec_idle", 32'(busy), 0);
        end

        // Minimum latency with immediate done responses
        wait_idle();
        e_delay = 1; d_delay = 1;
        req(7'd33, 7'd44, 3'd1);
        c0 = cyc;
        run_until_done(20, "lat_move_done");
        chk("min_latency", done_cyc - c0, 5);

        // Request landing in DONE is served after exactly one idle cycle
        req(7'd34, 7'd44, 3'd1);
        tick();
        chk("done_req_idle_gap", 32'(busy), 0);
        tick();
        chk("done_req_erase_go", 32'(erase_go), 1);
        run_until_done(20, "done_req_move_done");

        // Two requests during a move: only the latest survives
        wait_idle();
        e_delay = 5; d_delay = 5;
        base = n_draws;
        req(7'd11, 7'd20, 3'd1);
        tick(); tick();
        req(7'd11, 7'd21, 3'd2);
        tick();
        req(7'd12, 7'd21, 3'd3);
        run_until_done(40, "pend_first_done");
        chk("pend_first_draw", 32'({last_dx, last_dy, last_dc}), 32'({7'd11, 7'd20, 3'd1}));
        run_until_done(40, "pend_second_done");
        chk("pend_latest_draw", 32'({last_dx, last_dy, last_dc}), 32'({7'd12, 7'd21, 3'd3}));
        repeat (10) tick();
        chk("pend_draw_count", n_draws - base, 2);
        chk("pend_now_idle", 32'(busy), 0);

        // Stray draw_done in IDLE and during ERASE_WAIT
        wait_idle();
        base = n_done;
        stray_dd = 1'b1;
        tick(); tick();
        chk("stray_idle_busy", 32'({busy, move_done}), 0);
        chk("stray_idle_no_done", n_done - base, 0);
        e_delay = 8; d_delay = 2;
        req(7'd50, 7'd60, 3'd4);
        tick(); tick();
        stray_dd = 1'b1;
        tick(); tick();
        chk("stray_wait_hold", 32'({busy, draw_go}), 32'(2'b10));
        run_until_done(30, "stray_wait_move_done");

        // Watchdog instance (TIMEOUT=16)
        wait_idle();
        w_new_x = 7'd5; w_new_y = 7'd6; w_new_colour = 3'd3; w_move_req = 1'b1;
        tick(); w_move_req = 1'b0;
        chk("wd_first_draw_go", 32'(w_draw_go), 1);
        tick(); w_draw_done = 1'b1;
        tick(); w_draw_done = 1'b0;
        chk("wd_first_done", 32'(w_move_done), 1);
        tick();
        w_new_x = 7'd9; w_new_y = 7'd9; w_move_req = 1'b1;
        tick(); w_move_req = 1'b0;
        chk("wd_erase_go", 32'(w_erase_go), 1);
        wd_done_seen = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (w_move_done) wd_done_seen = 1'b1;
            if (i == 15) chk("wd_last_wait", 32'({w_busy, w_err}), 32'(2'b10));
        end
        tick();
        chk("wd_err_set", 32'({w_err, w_busy, wd_done_seen}), 32'(3'b100));
        chk("wd_cur_kept", 32'({w_erase_x, w_erase_y}), 32'({7'd5, 7'd6}));
        w_err_clr = 1'b1;
        tick(); w_err_clr = 1'b0;
        chk("wd_err_clr", 32'(w_err), 0);
        w_new_x = 7'd9; w_new_y = 7'd9; w_move_req = 1'b1;
        tick(); w_move_req = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (i == 1) begin w_new_x = 7'd20; w_new_y = 7'd20; w_move_req = 1'b1; end
            if (i == 2) w_move_req = 1'b0;
            if (i == 15) w_err_clr = 1'b1;
        end
        tick(); w_err_clr = 1'b0;
        chk("wd_set_wins", 32'({w_err, w_busy}), 32'(2'b10));
        repeat (3) tick();
        chk("wd_pending_dropped", 32'({w_busy, w_erase_go, w_draw_go}), 0);

        // Reset during DRAW_WAIT
        wait_idle();
        e_delay = 2; d_delay = 100;
        req(7'd30, 7'd40, 3'd6);
        for (int k = 0; k < 20 && phase != 2; k++) tick();
        tick(); tick();
        chk("pre_reset_busy", 32'(busy), 1);
        #2 resetn = 1'b0;
        #1;
        chk("async_reset_ctrl", 32'({busy, erase_go, draw_go, move_done, err, vga_x, vga_y, vga_colour, vga_plot}), 0);
        chk("async_reset_coords", 32'({erase_x, erase_y, draw_x, draw_y, draw_colour}), 0);
        exp_q.delete();
        m_busy = 0; m_pend = 0; m_have = 0; m_cx = 0; m_cy = 0; req_now = 0; done_now = 0;
        er_cnt = 0; dr_cnt = 0; phase = 0; end_phase = 0; er_fin = 0; n_started = n_done;
        @(negedge clock);
        resetn = 1'b1;
        e_delay = 2; d_delay = 2; saw_erase = 1'b0;
        req(7'd31, 7'd41, 3'd2);
        run_until_done(20, "post_reset_move_done");
        chk("post_reset_no_erase", 32'(saw_erase), 0);

        // Randomized requests against the model
        rand_delays = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(9, 0) == 0) req(7'($urandom), 7'($urandom), 3'($urandom));
            tick();
        end
        for (int k = 0; k < 200 && (m_busy || m_pend || done_now); k++) tick();
        rand_delays = 1'b0;
        chk("rand_drain_idle", 32'(busy), 0);
        chk("rand_queue_empty", exp_q.size(), 0);
        chk("rand_moves_completed", n_done, n_started);
        chk("rand_no_err", 32'(err), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
